// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: inter-stage registers with stall, bubble and flush control.
// Define PIPE_CTRL_PERF_CNT_EN to build the saturating performance counters.
module pipeline_ctrl #(
  parameter int STAGES      = 5,
  parameter int DATA_W      = 64,
  parameter int FLUSH_STAGE = 1,
  parameter int CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_valid,
  input  logic [(STAGES-1)*DATA_W-1:0] stage_out,
  input  logic [STAGES-2:0]            stage_ready,
  input  logic                         flush,
  output logic [(STAGES-1)*DATA_W-1:0] stage_in,
  output logic [STAGES-2:0]            stage_valid,
  output logic [STAGES-2:0]            hold,
  output logic                         fetch_advance,
  output logic                         flush_taken,
  output logic [CNT_W-1:0]             stall_cycles,
  output logic [CNT_W-1:0]             flush_count,
  output logic [CNT_W-1:0]             retired
);

  localparam int NR = STAGES - 1;
  localparam logic [NR-1:0] SQ_MASK =
    NR'((64'd1 << FLUSH_STAGE) - 64'd1);

  logic [NR-1:0]        valid_q, valid_d;
  logic [NR*DATA_W-1:0] data_q, data_d;
  logic [NR-1:0]        vin, er;
  logic [NR-1:0]        stall_hold, bubble, squash;
  logic                 stall;

  assign vin = {valid_q[NR-2:0], fetch_valid};
  assign er  = stage_ready | ~vin;

  // Scan from the oldest stage down to find the stall point.
  always_comb begin
    logic blk;
    blk        = 1'b0;
    stall_hold = '0;
    bubble     = '0;
    for (int i = NR-1; i >= 0; i--) begin
      stall_hold[i] = blk;
      bubble[i]     = ~er[i] & ~blk;
      blk           = blk | ~er[i];
    end
    stall = blk;
  end

  assign flush_taken = flush
                     & valid_q[FLUSH_STAGE-1]
                     & ~stall_hold[FLUSH_STAGE-1];
  assign squash        = {NR{flush_taken}} & SQ_MASK;
  assign hold          = stall_hold & ~squash;
  assign fetch_advance = ~stall;

  // Next register contents: squash/bubble, hold, or load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < NR; i++) begin
      if (squash[i] || bubble[i]) begin
        valid_d[i]                 = 1'b0;
        data_d[i*DATA_W +: DATA_W] = '0;
      end else if (!stall_hold[i]) begin
        valid_d[i]                 = vin[i];
        data_d[i*DATA_W +: DATA_W] = stage_out[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pipeline register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign stage_in    = data_q;
  assign stage_valid = valid_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  // Saturating counter increments.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_taken && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (valid_d[NR-1] && !(&ret_cnt_q))
      ret_cnt_d = ret_cnt_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      ret_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
  assign retired      = ret_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
  assign retired      = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl.
// Randomised stimulus against a queue-based behavioural model.
module tb_pipeline_ctrl;

  localparam int FS = 1;

`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid;
  logic [31:0] stage_out;
  logic [3:0]  stage_ready;
  logic        flush;
  logic [7:0]  fpay;

  logic [31:0] stage_in, stage_in_b;
  logic [3:0]  stage_valid, stage_valid_b;
  logic [3:0]  hold, hold_b;
  logic        fetch_advance, fetch_advance_b;
  logic        flush_taken, flush_taken_b;
  logic [31:0] sc, fc, rc;
  logic [3:0]  sc_b, fc_b, rc_b;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .STAGES(5), .DATA_W(8), .FLUSH_STAGE(FS), .CNT_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid),
    .stage_out(stage_out), .stage_ready(stage_ready),
    .flush(flush), .stage_in(stage_in),
    .stage_valid(stage_valid), .hold(hold),
    .fetch_advance(fetch_advance), .flush_taken(flush_taken),
    .stall_cycles(sc), .flush_count(fc), .retired(rc)
  );

  pipeline_ctrl #(
    .STAGES(5), .DATA_W(8), .FLUSH_STAGE(FS), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid),
    .stage_out(stage_out), .stage_ready(stage_ready),
    .flush(flush), .stage_in(stage_in_b),
    .stage_valid(stage_valid_b), .hold(hold_b),
    .fetch_advance(fetch_advance_b), .flush_taken(flush_taken_b),
    .stall_cycles(sc_b), .flush_count(fc_b), .retired(rc_b)
  );

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  hold;
    logic        fa;
    logic        ft;
    logic [31:0] sc, fc, rc;
    logic [3:0]  sc4, fc4, rc4;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   pops = 0;

  // Reference model: register contents as plain arrays.
  bit          mv [1:4];
  logic [7:0]  md [1:4];
  int unsigned m_sc, m_fc, m_rc;
  bit [3:0]    m_sc4, m_fc4, m_rc4;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] so_of(int i);
    if (i == 0) return fpay;
    return md[i] + 8'(i * 16 + 3);
  endfunction

  function automatic logic [31:0] build_so();
    return {so_of(3), so_of(2), so_of(1), so_of(0)};
  endfunction

  function automatic void model_reset();
    for (int j = 1; j <= 4; j++) begin
      mv[j] = 1'b0;
      md[j] = 8'h00;
    end
    m_sc = 0; m_fc = 0; m_rc = 0;
    m_sc4 = 0; m_fc4 = 0; m_rc4 = 0;
  endfunction

  // Present state -> expectation, then advance one edge.
  function automatic void step(output exp_t e);
    bit         v [0:3];
    int         k;
    bit         ft;
    bit         nv [1:4];
    logic [7:0] nd [1:4];
    v[0] = fetch_valid;
    for (int i = 1; i < 4; i++) v[i] = mv[i];
    k = -1;
    for (int i = 0; i < 4; i++)
      if (v[i] && !stage_ready[i]) k = i;
    ft = flush && mv[FS] && (k < FS);
    for (int j = 1; j <= 4; j++) begin
      e.v[j-1]         = mv[j];
      e.d[(j-1)*8 +: 8] = md[j];
      e.hold[j-1]      = (j <= k) && !(ft && j <= FS);
    end
    e.fa  = (k < 0);
    e.ft  = ft;
    e.sc  = PERF ? m_sc : 32'd0;
    e.fc  = PERF ? m_fc : 32'd0;
    e.rc  = PERF ? m_rc : 32'd0;
    e.sc4 = PERF ? m_sc4 : 4'd0;
    e.fc4 = PERF ? m_fc4 : 4'd0;
    e.rc4 = PERF ? m_rc4 : 4'd0;
    for (int j = 1; j <= 4; j++) begin
      if ((ft && j <= FS) || j == k + 1) begin
        nv[j] = 1'b0;
        nd[j] = 8'h00;
      end else if (j <= k) begin
        nv[j] = mv[j];
        nd[j] = md[j];
      end else begin
        nv[j] = (j == 1) ? fetch_valid : mv[j-1];
        nd[j] = so_of(j - 1);
      end
    end
    if (k >= 0) begin
      if (m_sc != 32'hFFFF_FFFF) m_sc++;
      if (m_sc4 != 4'hF) m_sc4++;
    end
    if (ft) begin
      if (m_fc != 32'hFFFF_FFFF) m_fc++;
      if (m_fc4 != 4'hF) m_fc4++;
    end
    if (nv[4]) begin
      if (m_rc != 32'hFFFF_FFFF) m_rc++;
      if (m_rc4 != 4'hF) m_rc4++;
    end
    for (int j = 1; j <= 4; j++) begin
      mv[j] = nv[j];
      md[j] = nd[j];
    end
  endfunction

  task automatic cyc(input logic f, input logic [7:0] p,
                     input logic [3:0] r, input logic fl);
    exp_t e;
    @(posedge clk);
    #1;
    fetch_valid = f;
    fpay        = p;
    stage_ready = r;
    flush       = fl;
    stage_out   = build_so();
    step(e);
    q.push_back(e);
    pushes++;
  endtask

  task automatic rnd(input int n, input int flush_pct);
    logic [3:0] r;
    repeat (n) begin
      for (int b = 0; b < 4; b++) r[b] = ($urandom % 4) != 0;
      cyc(1'($urandom % 2), 8'($urandom), r,
          ($urandom % 100) < flush_pct);
    end
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    fpay        = 8'h00;
    stage_ready = 4'($urandom);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(stage_valid), 64'd0);
    chk("rst_data", 64'(stage_in), 64'd0);
    chk("rst_hold", 64'(hold), 64'd0);
    chk("rst_fadv", 64'(fetch_advance), 64'd1);
    chk("rst_ftak", 64'(flush_taken), 64'd0);
    chk("rst_cnt", {sc, fc}, 64'd0);
    chk("rst_cnt_r", {rc, 4'd0, sc_b, fc_b, rc_b}, 64'd0);
    model_reset();
    stage_out = build_so();
    step(e);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare DUT against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      pops++;
      chk("valid", 64'(stage_valid), 64'(me.v));
      chk("data", 64'(stage_in), 64'(me.d));
      chk("hold", 64'(hold), 64'(me.hold));
      chk("fetch_adv", 64'(fetch_advance), 64'(me.fa));
      chk("flush_taken", 64'(flush_taken), 64'(me.ft));
      chk("stall_cycles", 64'(sc), 64'(me.sc));
      chk("flush_count", 64'(fc), 64'(me.fc));
      chk("retired", 64'(rc), 64'(me.rc));
      chk("stall_sat4", 64'(sc_b), 64'(me.sc4));
      chk("flush_sat4", 64'(fc_b), 64'(me.fc4));
      chk("retired_sat4", 64'(rc_b), 64'(me.rc4));
      chk("narrow_ctrl", 64'({hold_b, fetch_advance_b, flush_taken_b}),
          64'({me.hold, me.fa, me.ft}));
    end
  end

  initial begin
    fetch_valid = 1'b0;
    flush       = 1'b0;
    stage_ready = 4'hF;
    fpay        = 8'h00;
    stage_out   = '0;
    model_reset();
    do_reset();
    // streaming
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 8'(8'h10 + i), 4'hF, 1'b0);
    // short stall at stage 2, then release
    repeat (3) cyc(1'b1, 8'h20, 4'b1011, 1'b0);
    repeat (4) cyc(1'b1, 8'h21, 4'hF, 1'b0);
    // single flush, no stall
    cyc(1'b1, 8'h30, 4'hF, 1'b1);
    repeat (4) cyc(1'b1, 8'h31, 4'hF, 1'b0);
    // flush blocked by stage 3, then honoured on release
    repeat (2) cyc(1'b1, 8'h40, 4'b0111, 1'b1);
    cyc(1'b1, 8'h41, 4'hF, 1'b1);
    repeat (3) cyc(1'b1, 8'h42, 4'hF, 1'b0);
    // long stall to saturate the narrow counter
    repeat (20) cyc(1'b1, 8'h50, 4'b1011, 1'b0);
    repeat (4) cyc(1'b1, 8'h51, 4'hF, 1'b0);
    // random traffic, mid-run reset, more random
    rnd(600, 12);
    do_reset();
    rnd(600, 25);
    repeat (6) cyc(1'b1, 8'($urandom), 4'hF, 1'b0);
    do_reset();
    rnd(300, 10);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", 64'(pops), 64'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised pipeline-register and hazard-control block for the RISC-V core. It holds the inter-stage registers (payload plus valid bit) for an N-stage in-order pipeline and derives stall, bubble and flush behaviour from per-stage ready signals and a redirect (jump) request. Stage count and payload width are parameters, and bubbles are marked by an explicit valid bit rather than a zeroed payload. An optional set of saturating performance counters can be compiled in.

## Interface
- `STAGES`, default 5: pipeline stages, index 0 is fetch; must be ≥ 3.
- `DATA_W`, default 64: payload width carried between stages.
- `FLUSH_STAGE`, default 1: index of the stage that raises `flush` (decode); must be 1..STAGES-2.
- `CNT_W`, default 32: performance counter width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `fetch_valid`  in  1: stage 0 output is a real instruction.
- `stage_out`  in  (STAGES-1)*DATA_W: output of stage i at `[i*DATA_W +: DATA_W]`, i = 0..STAGES-2.
- `stage_ready`  in  STAGES-1: stage i has finished its current content.
- `flush`  in  1: redirect request from stage FLUSH_STAGE.
- `stage_in`  out  (STAGES-1)*DATA_W: register R[j] feeding stage j at `[(j-1)*DATA_W +: DATA_W]`, j = 1..STAGES-1.
- `stage_valid`  out  STAGES-1: valid bit of R[j] at bit j-1.
- `hold`  out  STAGES-1: R[j] holds this cycle.
- `fetch_advance`  out  1: PC may advance.
- `flush_taken`  out  1: flush honoured this cycle.
- `stall_cycles`, `flush_count`, `retired`  out  CNT_W each: performance counters.

## Operation
- Effective ready: `er[i] = stage_ready[i]`, or 1 when the stage holds a bubble (valid of R[i] is 0; for i = 0, `fetch_valid` = 0).
- Stall point: `k` = highest i with `er[i]` = 0; "none" if all are ready.
- Per-edge register update:
  - j ≤ k: R[j] holds, and `hold[j-1]` = 1.
  - j = k+1: R[j] loads a bubble (valid 0, payload 0).
  - j > k+1, or no stall: R[j] ← `stage_out[j-1]` with valid ← valid of R[j-1] (for j = 1, `fetch_valid`).
- `fetch_advance` = 1 iff no stall.
- Flush:
  - Honoured (`flush_taken` = 1) iff `flush` = 1, R[FLUSH_STAGE] is valid, and (no stall or k < FLUSH_STAGE).
  - When honoured, R[1..FLUSH_STAGE] load bubbles. R[FLUSH_STAGE+1] loads the flushing stage's output normally.
  - Flush raised while k ≥ FLUSH_STAGE is ignored. The source keeps it asserted because its input is held.
- Flush overrides stall bubbling for R[1..FLUSH_STAGE]; the result is a bubble either way.
- A stall at k = STAGES-2 bubbles R[STAGES-1]; downstream writeback sees valid 0.

## Timing
- All registers reset asynchronously on `rst_n` low, immediately and without waiting for `clk`:
  - every `stage_valid` = 0, every `stage_in` = 0;
  - counters = 0.
- During reset:
  - `hold` = 0;
  - `fetch_advance` = 1, because all stages are bubbles and therefore effectively ready;
  - `flush_taken` = 0.
- Reset release is synchronised by the environment. The first load occurs at the first rising edge with `rst_n` high.
- Latency is one cycle per stage: data presented at `stage_out[i]` appears on R[i+1] after the next edge.
- `hold`, `fetch_advance` and `flush_taken` are combinational from `stage_ready`, `flush`, `fetch_valid` and the register valids (zero latency). There is no combinational path from `stage_out` to any control output.
- Reset asserted mid-stall or mid-flush discards all in-flight entries. Nothing is retained.

## Configuration
- Macro `PIPE_CTRL_PERF_CNT_EN`.
- Defined, the three counters are active and saturate at 2^CNT_W-1 (no wrap):
  - `stall_cycles`: +1 per cycle with a stall point present.
  - `flush_count`: +1 per `flush_taken`.
  - `retired`: +1 per edge that loads a valid entry into R[STAGES-1].
- Undefined: the counter ports remain and are driven constant 0, and no counter flops are synthesised.

## Test plan
All scenarios use STAGES=5, DATA_W=8, FLUSH_STAGE=1, with `PIPE_CTRL_PERF_CNT_EN` defined; the bench echoes stage i output = R[i] payload.
- Reset: load valid data, pull `rst_n` low between edges → all `stage_valid` = 0 and `stage_in` = 0 before the next edge; counters 0.
- Streaming: `fetch_valid`=1 with payload 0x10, all ready → 0x10 on R[1] after 1 edge and on R[4] after 4 edges with valid 1; `retired`=1.
- Stall: `stage_ready[2]`=0 for 3 cycles with R[2] valid → R[1] and R[2] hold, R[3] valid=0 for 3 edges, `fetch_advance`=0, `stall_cycles`=3; on release, the held data resumes in order.
- Flush: `flush`=1 for one cycle with R[1] valid, no stall → `flush_taken`=1, R[1] valid=0 next edge, R[2] loads decode output, `flush_count`=1.
- Blocked flush: `stage_ready[3]`=0 with `flush`=1 → `flush_taken`=0 and no squash; release ready → `flush_taken`=1 in that cycle.
- Saturation with CNT_W=4: 20 consecutive stall cycles → `stall_cycles`=15; macro undefined → all counters read 0.
